// File: rtl/seq_det_pkg.sv
`default_nettype none
//==============================================================================
// Module      : seq_det_pkg
// Description : Shared types and constants for the multi-channel "101"
//               sequence detector. The overlap mode is fixed at build time
//               by the SEQ_OVERLAP_EN macro.
// Revision    : 1.0 - initial release
//==============================================================================
package seq_det_pkg;

   // Detector states; encoding 3 is unreachable and treated as A.
   typedef enum logic [1:0] {
      ST_A = 2'd0,
      ST_B = 2'd1,
      ST_C = 2'd2,
      ST_X = 2'd3
   } state_t;

`ifdef SEQ_OVERLAP_EN
   localparam bit c_overlap_en = 1'b1;
`else
   localparam bit c_overlap_en = 1'b0;
`endif

   // State entered after a completed match: B keeps the trailing '1'
   // so it can start the next pattern.
   localparam state_t c_match_next = c_overlap_en ? ST_B : ST_A;

endpackage
`default_nettype wire

// File: rtl/seq_det_step.sv
`default_nettype none
//==============================================================================
// Module      : seq_det_step
// Description : Combinational Mealy next-state / match function of the "101"
//               detector, shared by every channel.
// Revision    : 1.0 - initial release
//==============================================================================
module seq_det_step
   import seq_det_pkg::*;
(
   input  state_t state,
   input  logic   bit_in,
   output state_t next,
   output logic   match
);

   // Next state and match flag for one serial bit
   always_comb begin
      next  = ST_A;
      match = 1'b0;
      case (state)
         ST_A: next = bit_in ? ST_B : ST_A;
         ST_B: next = bit_in ? ST_B : ST_C;
         ST_C: begin
            if (bit_in) begin
               match = 1'b1;
               next  = c_match_next;
            end else begin
               next  = ST_A;
            end
         end
         default: next = ST_A;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seq_det_sched.sv
`default_nettype none
//==============================================================================
// Module      : seq_det_sched
// Description : NCH serial channels share one "101" detector through a
//               round-robin grant. Each channel keeps its own state; matches
//               are reported one cycle after the completing transfer and
//               counted in a saturating counter.
//               Build option: SEQ_OVERLAP_EN selects overlapping detection.
// Revision    : 1.0 - initial release
//==============================================================================
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NCH-1:0]         ch_valid,
   input  logic [NCH-1:0]         ch_bit,
   output logic [NCH-1:0]         ch_ready,
   input  logic [NCH-1:0]         ch_clear,
   output logic                   det_valid,
   output logic [$clog2(NCH)-1:0] det_ch,
   output logic [CNT_W-1:0]       match_cnt
);

   localparam int                 c_ptr_w = $clog2(NCH);
   localparam logic [c_ptr_w:0]   c_nch   = (c_ptr_w+1)'(NCH);
   localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(NCH - 1);
   localparam logic [NCH-1:0]     c_one   = NCH'(1);

   state_t               r_state [NCH];
   logic [c_ptr_w-1:0]   r_ptr;
   logic                 r_det_valid;
   logic [c_ptr_w-1:0]   r_det_ch;
   logic [CNT_W-1:0]     r_match_cnt;

   logic [2*NCH-1:0]     w_dbl;
   logic [NCH-1:0]       w_rot;
   logic [c_ptr_w-1:0]   w_off;
   logic [c_ptr_w:0]     w_sum;
   logic [c_ptr_w-1:0]   w_gidx;
   logic                 w_xfer;
   logic                 w_hit;
   logic                 w_match;
   state_t               w_cur;
   state_t               w_next;

   // Rotate the requests so the pointer position lands on bit 0; the first
   // set bit is then the offset of the winner from the pointer.
   assign w_dbl = {ch_valid, ch_valid} >> r_ptr;
   assign w_rot = w_dbl[NCH-1:0];

   // Lowest set bit of the rotated request vector
   always_comb begin
      w_off = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = c_ptr_w'(i);
      end
   end

   assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_gidx   = (w_sum >= c_nch) ? c_ptr_w'(w_sum - c_nch) : w_sum[c_ptr_w-1:0];
   assign w_xfer   = resetn & (|ch_valid);
   assign ch_ready = w_xfer ? (c_one << w_gidx) : '0;

   // A clear on the granted channel swallows the bit, so no match escapes.
   assign w_cur = r_state[w_gidx];
   assign w_hit = w_xfer & w_match & ~ch_clear[w_gidx];

   seq_det_step u_step (
      .state  (w_cur),
      .bit_in (ch_bit[w_gidx]),
      .next   (w_next),
      .match  (w_match)
   );

   // Per-channel detector state: clear has priority over the granted update
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < NCH; k++) r_state[k] <= ST_A;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (ch_clear[k])       r_state[k] <= ST_A;
            else if (ch_ready[k])  r_state[k] <= w_next;
         end
      end
   end

   // Round-robin pointer, registered match report and saturating counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ptr       <= '0;
         r_det_valid <= 1'b0;
         r_det_ch    <= '0;
         r_match_cnt <= '0;
      end else begin
         if (w_xfer) r_ptr <= (w_gidx == c_last) ? '0 : w_gidx + c_ptr_w'(1);
         r_det_valid <= w_hit;
         if (w_hit) begin
            r_det_ch <= w_gidx;
            if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + CNT_W'(1);
         end
      end
   end

   assign det_valid = r_det_valid;
   assign det_ch    = r_det_ch;
   assign match_cnt = r_match_cnt;

endmodule
`default_nettype wire
